// File: rtl/fft_8_rad2.sv
// fft_8_rad2 -- 8-point radix-2 decimation-in-frequency FFT.
//
// Stage 0 is one combinational butterfly on the two incoming samples,
// written into an 8-entry buffer over four enabled cycles. Stage 1 and
// stage 2 are registered, four butterflies each, and run on their own
// once a frame is complete. The result is written to fft_out in natural
// order with a one-cycle out_valid pulse. One frame is accepted every
// four enabled cycles.
//
// Ports
//   clk        : clock, rising edge
//   reset      : asynchronous, active-low reset
//   enable     : qualifies capture of data_0/data_1
//   data_0     : sample x[k] during input cycle k = 0..3
//   data_1     : sample x[k+4] during input cycle k
//   W_R_STAGE  : twiddle real parts [stage][butterfly], Q8 (256 = 1.0)
//   W_I_STAGE  : twiddle imaginary parts [stage][butterfly], Q8
//   fft_out    : X[0..7], natural order, held until the next frame
//   out_valid  : one-cycle pulse when fft_out holds a new frame

package fft_8_rad2_pkg;
  typedef struct packed {
    logic signed [31:0] r;
    logic signed [31:0] i;
  } complex_product_t;
endpackage

module fft_8_rad2
  import fft_8_rad2_pkg::*;
#(
  parameter  int N               = 8,
  localparam int NUM_STAGES      = $clog2(N),
  localparam int NUM_BUTTERFLIES = N / 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  complex_product_t         data_0,
  input  complex_product_t         data_1,
  input  logic signed [15:0]       W_R_STAGE [NUM_STAGES][NUM_BUTTERFLIES],
  input  logic signed [15:0]       W_I_STAGE [NUM_STAGES][NUM_BUTTERFLIES],
  output complex_product_t [N-1:0] fft_out,
  output logic                     out_valid
);

  function automatic complex_product_t cadd(input complex_product_t a, input complex_product_t b);
    complex_product_t v_s;
    v_s.r = a.r + b.r;
    v_s.i = a.i + b.i;
    return v_s;
  endfunction

  function automatic complex_product_t csub(input complex_product_t a, input complex_product_t b);
    complex_product_t v_d;
    v_d.r = a.r - b.r;
    v_d.i = a.i - b.i;
    return v_d;
  endfunction

  // Products are formed at full width; the >>> 8 floors toward -inf and
  // the result wraps to 32 bits.
  function automatic complex_product_t cmul(input complex_product_t d,
                                            input logic signed [15:0] wr,
                                            input logic signed [15:0] wi);
    logic signed [48:0] v_dr, v_di, v_wr, v_wi;
    complex_product_t   v_p;
    v_dr = {{17{d.r[31]}}, d.r};
    v_di = {{17{d.i[31]}}, d.i};
    v_wr = {{33{wr[15]}}, wr};
    v_wi = {{33{wi[15]}}, wi};
    v_p.r = 32'((v_dr * v_wr - v_di * v_wi) >>> 8);
    v_p.i = 32'((v_dr * v_wi + v_di * v_wr) >>> 8);
    return v_p;
  endfunction

  function automatic logic [2:0] bitrev3(input logic [2:0] p);
    return {p[0], p[1], p[2]};
  endfunction

  logic [1:0]               r_k;
  logic                     r_frame_done;
  logic                     r_s1_valid;
  logic                     r_out_valid;
  complex_product_t [N-1:0] r_buf;
  complex_product_t [N-1:0] r_s1;
  complex_product_t [N-1:0] r_fft_out;
  complex_product_t [N-1:0] w_s1_next;
  complex_product_t [N-1:0] w_s1_view;
  complex_product_t [N-1:0] w_out;

  complex_product_t butterfly_0_x;
  complex_product_t butterfly_0_y;
  complex_product_t butterfly_1_x;
  complex_product_t butterfly_1_y;

  // Stage 0: x[k] and x[k+4] arrive together, so the first DIF butterfly
  // is done on the fly with the twiddle for the current input cycle.
  assign butterfly_0_x = cadd(data_0, data_1);
  assign butterfly_0_y = cmul(csub(data_0, data_1), W_R_STAGE[0][r_k], W_I_STAGE[0][r_k]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_k          <= '0;
      r_buf        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= enable && (r_k == 2'd3);
      if (enable) begin
        r_buf[{1'b0, r_k}] <= butterfly_0_x;
        r_buf[{1'b1, r_k}] <= butterfly_0_y;
        r_k                <= r_k + 2'd1;
      end
    end
  end

  // Stage 1: pairs (0,2),(1,3),(4,6),(5,7). The buffer is read on the edge
  // that already overwrites entries 0/4 with the next frame, so a
  // back-to-back frame does not disturb the one being transformed.
  always_comb begin
    w_s1_next = '0;
    for (int b = 0; b < NUM_BUTTERFLIES; b++) begin
      w_s1_next[3'(b + (b & 2))]     = cadd(r_buf[3'(b + (b & 2))], r_buf[3'(b + (b & 2) + 2)]);
      w_s1_next[3'(b + (b & 2) + 2)] = cmul(csub(r_buf[3'(b + (b & 2))], r_buf[3'(b + (b & 2) + 2)]),
                                            W_R_STAGE[1][2'(b)], W_I_STAGE[1][2'(b)]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1       <= '0;
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_valid <= r_frame_done;
      if (r_frame_done) begin
        r_s1 <= w_s1_next;
      end
    end
  end

  assign butterfly_1_x = r_s1[0];
  assign butterfly_1_y = r_s1[2];

  // Stage 2 sees butterfly 0 of stage 1 through its named taps.
  always_comb begin
    w_s1_view    = r_s1;
    w_s1_view[0] = butterfly_1_x;
    w_s1_view[2] = butterfly_1_y;
  end

  // Stage 2: pairs (0,1),(2,3),(4,5),(6,7), scattered to natural order.
  always_comb begin
    w_out = '0;
    for (int b = 0; b < NUM_BUTTERFLIES; b++) begin
      w_out[bitrev3(3'(2 * b))]     = cadd(w_s1_view[3'(2 * b)], w_s1_view[3'(2 * b + 1)]);
      w_out[bitrev3(3'(2 * b + 1))] = cmul(csub(w_s1_view[3'(2 * b)], w_s1_view[3'(2 * b + 1)]),
                                           W_R_STAGE[2][2'(b)], W_I_STAGE[2][2'(b)]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fft_out   <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_fft_out <= w_out;
      end
    end
  end

  assign fft_out   = r_fft_out;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_fft_8_rad2.sv
// Bench for fft_8_rad2: directed frames, a plain-arithmetic DFT-by-DIF
// model scheduled by edge count, and literal expected spectra.
module tb_fft_8_rad2;
  import fft_8_rad2_pkg::*;

  typedef complex_product_t [7:0] frame_t;

  logic             clk    = 1'b0;
  logic             reset  = 1'b1;
  logic             enable = 1'b0;
  complex_product_t data_0 = '0;
  complex_product_t data_1 = '0;
  logic signed [15:0] w_r [3][4];
  logic signed [15:0] w_i [3][4];
  frame_t           fft_out;
  logic             out_valid;

  int     n_vec    = 0;
  int     n_err    = 0;
  int     edge_cnt = 0;
  int     due_q[$];
  frame_t exp_q[$];
  frame_t held     = '0;
  frame_t asm_x    = '0;
  int     asm_n    = 0;

  fft_8_rad2 dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .data_0    (data_0),
    .data_1    (data_1),
    .W_R_STAGE (w_r),
    .W_I_STAGE (w_i),
    .fft_out   (fft_out),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic complex_product_t mk(input int r, input int i);
    complex_product_t c;
    c.r = r;
    c.i = i;
    return c;
  endfunction

  // In-place DIF over the whole frame, then bit-reversed readout.
  function automatic frame_t model_fft(input frame_t x);
    frame_t a, y;
    int half, i0, i1, dr, di, q;
    longint pr, pi;
    complex_product_t u, v;
    a = x;
    for (int s = 0; s < 3; s++) begin
      half = 4 >> s;
      for (int b = 0; b < 4; b++) begin
        i0 = (b / half) * 2 * half + (b % half);
        i1 = i0 + half;
        u = a[i0];
        v = a[i1];
        a[i0].r = u.r + v.r;
        a[i0].i = u.i + v.i;
        dr = u.r - v.r;
        di = u.i - v.i;
        pr = longint'(dr) * longint'(w_r[s][b]) - longint'(di) * longint'(w_i[s][b]);
        pi = longint'(dr) * longint'(w_i[s][b]) + longint'(di) * longint'(w_r[s][b]);
        a[i1].r = int'(pr >>> 8);
        a[i1].i = int'(pi >>> 8);
      end
    end
    for (int p = 0; p < 8; p++) begin
      q = ((p & 1) << 2) | (p & 2) | ((p >> 2) & 1);
      y[q] = a[p];
    end
    return y;
  endfunction

  task automatic chk_bit(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b, required %0b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_frame(input string nm, input frame_t act, input frame_t exp);
    for (int k = 0; k < 8; k++) begin
      n_vec++;
      if (act[k] !== exp[k]) begin
        n_err++;
        $display("FAIL %s X%0d: got (%0d,%0d), required (%0d,%0d) (t=%0t)",
                 nm, k, act[k].r, act[k].i, exp[k].r, exp[k].i, $time);
      end
    end
  endtask

  // Checks every cycle: pulse and new spectrum when due, otherwise no
  // pulse and the previous spectrum held.
  always @(negedge clk) begin
    if (due_q.size() > 0 && due_q[0] == edge_cnt) begin
      chk_bit("out_valid at due cycle", out_valid, 1'b1);
      chk_frame("model", fft_out, exp_q[0]);
      held = exp_q[0];
      void'(due_q.pop_front());
      void'(exp_q.pop_front());
    end else begin
      chk_bit("out_valid idle", out_valid, 1'b0);
      chk_frame("hold", fft_out, held);
    end
  end

  task automatic push_cycle(input complex_product_t d0, input complex_product_t d1);
    @(negedge clk);
    enable = 1'b1;
    data_0 = d0;
    data_1 = d1;
    asm_x[asm_n]     = d0;
    asm_x[asm_n + 4] = d1;
    asm_n++;
    if (asm_n == 4) begin
      due_q.push_back(edge_cnt + 3);
      exp_q.push_back(model_fft(asm_x));
      asm_n = 0;
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      enable = 1'b0;
      data_0 = mk(12345, -678);
      data_1 = mk(-99, 4321);
    end
  endtask

  task automatic send_frame(input frame_t x);
    for (int k = 0; k < 4; k++) push_cycle(x[k], x[k + 4]);
  endtask

  task automatic wait_valid(input frame_t lit, input string nm);
    int  t;
    bit  seen;
    t    = 0;
    seen = 1'b0;
    while (!seen && t < 12) begin
      @(negedge clk);
      enable = 1'b0;
      t++;
      if (out_valid) seen = 1'b1;
    end
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL %s: no out_valid within 12 cycles, required a pulse", nm);
    end else begin
      chk_frame(nm, fft_out, lit);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset  = 1'b0;
    enable = 1'b0;
    asm_n  = 0;
    due_q.delete();
    exp_q.delete();
    held   = '0;
    repeat (2) @(negedge clk);
    #2;
    reset  = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    frame_t f029, f_imp, f_dc, f_odd, lit029, lit_imp, lit_dc;
    complex_product_t exp_y[4];

    w_r = '{'{16'sd256, 16'sd181, 16'sd0, -16'sd181},
            '{16'sd256, 16'sd0, 16'sd256, 16'sd0},
            '{16'sd256, 16'sd256, 16'sd256, 16'sd256}};
    w_i = '{'{16'sd0, -16'sd181, -16'sd256, -16'sd181},
            '{16'sd0, -16'sd256, 16'sd0, -16'sd256},
            '{16'sd0, 16'sd0, 16'sd0, 16'sd0}};

    f029 = '0;
    for (int k = 0; k < 4; k++) f029[k] = mk(256, 0);
    f_imp    = '0;
    f_imp[0] = mk(256, 0);
    for (int k = 0; k < 8; k++) f_dc[k] = mk(256, 0);
    f_odd[0] = mk(2000000000, -2000000000);
    f_odd[1] = mk(-5, 77);
    f_odd[2] = mk(123, -456);
    f_odd[3] = mk(-999, 3);
    f_odd[4] = mk(1000000000, 5);
    f_odd[5] = mk(-300, 251);
    f_odd[6] = mk(55, -1);
    f_odd[7] = mk(-17, -129);

    lit029    = '0;
    lit029[0] = mk(1024, 0);
    lit029[1] = mk(256, -618);
    lit029[3] = mk(256, -106);
    lit029[5] = mk(256, 106);
    lit029[7] = mk(256, 618);
    for (int k = 0; k < 8; k++) lit_imp[k] = mk(256, 0);
    lit_dc    = '0;
    lit_dc[0] = mk(2048, 0);

    exp_y[0] = mk(256, 0);
    exp_y[1] = mk(181, -181);
    exp_y[2] = mk(0, -256);
    exp_y[3] = mk(-181, -181);

    #1 reset = 1'b0;
    @(negedge clk);
    chk_bit("reset out_valid", out_valid, 1'b0);
    chk_frame("reset fft_out", fft_out, '0);
    @(negedge clk);
    #2 reset = 1'b1;

    // Reference frame, with the stage-0 difference output watched per cycle.
    for (int k = 0; k < 4; k++) begin
      push_cycle(f029[k], f029[k + 4]);
      #1;
      n_vec++;
      if (dut.butterfly_0_y !== exp_y[k]) begin
        n_err++;
        $display("FAIL butterfly_0_y k=%0d: got (%0d,%0d), required (%0d,%0d)",
                 k, dut.butterfly_0_y.r, dut.butterfly_0_y.i, exp_y[k].r, exp_y[k].i);
      end
    end
    wait_valid(lit029, "ref frame");

    send_frame(f_imp);
    wait_valid(lit_imp, "impulse");

    send_frame(f_dc);
    wait_valid(lit_dc, "dc");

    // Enable gap of three cycles between input cycles 1 and 2.
    push_cycle(f029[0], f029[4]);
    push_cycle(f029[1], f029[5]);
    idle_cycles(3);
    push_cycle(f029[2], f029[6]);
    push_cycle(f029[3], f029[7]);
    wait_valid(lit029, "gapped frame");

    // Partial frame discarded by reset.
    push_cycle(f_dc[0], f_dc[4]);
    push_cycle(f_dc[1], f_dc[5]);
    do_reset();
    send_frame(f029);
    wait_valid(lit029, "post-reset frame");

    // Back-to-back frames.
    send_frame(f029);
    send_frame(f_dc);
    idle_cycles(8);

    // Odd and wrapping values exercise floor and 32-bit wrap.
    send_frame(f_odd);
    idle_cycles(8);

    n_vec++;
    if (due_q.size() != 0) begin
      n_err++;
      $display("FAIL pending frames: %0d still expected, required 0", due_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fft_8_rad2.md
FFT_8_RAD2 -- requirements
Module: fft_8_rad2

Interface
REQ-001 SHALL have parameter N, default 8, meaning FFT size; only N=8 is supported; NUM_STAGES=$clog2(N)=3, NUM_BUTTERFLIES=N/2=4.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port enable, input, 1 bit: qualifies input sample capture.
REQ-005 SHALL have port data_0, input, complex_product_t (signed 32-bit r, i): sample x[k] during input cycle k=0..3.
REQ-006 SHALL have port data_1, input, complex_product_t: sample x[k+4] during input cycle k.
REQ-007 SHALL have port W_R_STAGE, input, signed [15:0] [3][4]: twiddle real part per stage/butterfly, Q8 (256 = 1.0).
REQ-008 SHALL have port W_I_STAGE, input, signed [15:0] [3][4]: twiddle imaginary part, Q8.
REQ-009 SHALL have port fft_out, output, complex_product_t [N-1:0]: X[0..7], natural order.
REQ-010 SHALL have port out_valid, output, 1 bit: one-cycle pulse when fft_out holds a new frame.

Function
REQ-011 Algorithm SHALL be radix-2 decimation-in-frequency; butterfly (a,b) gives x=a+b, y=(a-b)*W.
REQ-012 Complex multiply SHALL use full-precision products, then arithmetic shift right by 8 (floor), truncated to 32 bits; no saturation, two's-complement wrap.
REQ-013 Stage 0 SHALL be one combinational butterfly on (data_0, data_1) with twiddle W_*_STAGE[0][k], k = input counter; its outputs SHALL exist as internal signals butterfly_0_x and butterfly_0_y.
REQ-014 On each rising edge with enable=1, butterfly_0_x SHALL be stored at buffer index k, butterfly_0_y at index k+4, and the 2-bit counter k SHALL increment and wrap 3->0.
REQ-015 When enable=0, the counter and buffer SHALL hold.
REQ-016 The edge storing k=3 SHALL raise a one-cycle frame-complete flag.
REQ-017 On the edge following frame-complete, stage 1 SHALL register 4 parallel butterflies b=0..3 on pairs (0,2),(1,3),(4,6),(5,7) with twiddle [1][b].
REQ-018 Stage-1 butterfly 0 registered outputs SHALL exist as internal signals butterfly_1_x and butterfly_1_y.
REQ-019 On the next edge, stage 2 SHALL compute pairs (0,1),(2,3),(4,5),(6,7) with twiddle [2][b] for b=0..3.
REQ-020 On that same edge, stage-2 position p SHALL be written to fft_out[bitrev3(p)] and out_valid SHALL be set to 1.
REQ-021 Stages 1 and 2 SHALL advance regardless of enable.
REQ-022 Latency SHALL be: out_valid high during the cycle after the 6th enabled rising edge of a frame (frame-complete +2 edges).
REQ-023 out_valid SHALL deassert after one cycle; fft_out SHALL hold until the next frame's result.
REQ-024 Back-to-back frames (enable held high) SHALL be accepted with throughput of one frame per 4 cycles and no sample loss.
REQ-025 Twiddle inputs SHALL be sampled combinationally at use; the design SHALL NOT store them.
REQ-026 Nominal table (r,i): stage0 = (256,0),(181,-181),(0,-256),(-181,-181); stage1 = (256,0),(0,-256),(256,0),(0,-256); stage2 = all (256,0).

Reset
REQ-027 reset=0 SHALL immediately clear the counter, buffer, stage registers, frame-complete flag, all fft_out entries (0,0) and out_valid.
REQ-028 reset asserted mid-frame SHALL discard the partial frame; the first enabled edge after release SHALL be input cycle k=0.

Verification
REQ-029 Four enabled cycles of data_0=(256,0), data_1=(0,0), nominal twiddles -> out_valid pulse with X0=(1024,0), X1=(256,-618), X2=(0,0), X3=(256,-106), X4=(0,0), X5=(256,106), X6=(0,0), X7=(256,618).
REQ-030 Same stimulus -> butterfly_0_y, sampled before each edge k=0..3, SHALL equal (256,0), (181,-181), (0,-256), (-181,-181).
REQ-031 Impulse x[0]=(256,0), all other samples 0 -> every X[k]=(256,0); DC input of all samples (256,0) -> X0=(2048,0), all others (0,0).
REQ-032 Deassert enable for 3 cycles between input cycles 1 and 2 -> results identical to REQ-029; out_valid delayed by 3 cycles.
REQ-033 Assert reset after 2 input cycles, then apply a full frame -> out_valid only once, with results from the post-reset frame only.
REQ-034 Two consecutive frames without gaps (REQ-029 frame, then DC frame) -> two out_valid pulses 4 cycles apart, each with correct results.
